// File: rtl/store_buffer_unit.sv
// Store path: decodes RISC-V store funct3, lane-aligns data and strobes, and queues legal
// stores in a DEPTH-entry in-order FIFO drained to memory. Build option: STORE_BUF_FWD_EN.
module store_buffer_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [XLEN-1:0]          req_data,
  output logic                     misalign,
  input  logic                     flush,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data,
  output logic [XLEN/8-1:0]        fwd_strb
);

  localparam int STRB_W = XLEN / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and mem_* hold steady while mem_valid is high and
  // mem_ready low. req_ready is based on the registered count only (no same-cycle pop).

  logic [LANE_W-1:0] laneOff;
  logic [LANE_W-1:0] alignMask;
  logic [STRB_W-1:0] sizeStrb;
  logic [XLEN-1:0]   dataMask;
  logic              legalOp;
  logic              misalignedAddr;
  logic              reqLegal;
  logic [XLEN-1:0]   laneWdata;
  logic [STRB_W-1:0] laneWstrb;
  logic [ADDR_W-1:0] wordAddr;

  logic              accept;
  logic              push;
  logic              pop;

  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  occupancy;
  logic              misalignQ;

  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [XLEN-1:0]   entData [DEPTH];
  logic [STRB_W-1:0] entStrb [DEPTH];

  assign laneOff  = req_addr[LANE_W-1:0];
  assign wordAddr = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  // Size decode: sizeStrb is the unshifted byte mask, alignMask the offset bits that must be 0.
  always_comb begin
    sizeStrb  = '0;
    alignMask = '0;
    legalOp   = 1'b1;
    case (req_funct3)
      3'b000: sizeStrb = STRB_W'(1);
      3'b001: begin
        sizeStrb  = STRB_W'(2'b11);
        alignMask = LANE_W'(1);
      end
      3'b010: begin
        sizeStrb  = STRB_W'(4'hF);
        alignMask = LANE_W'(3);
      end
      3'b011: begin
        if (XLEN == 64) begin
          sizeStrb  = '1;
          alignMask = LANE_W'(7);
        end else begin
          legalOp = 1'b0;
        end
      end
      default: legalOp = 1'b0;
    endcase
  end

  always_comb begin
    dataMask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      dataMask[8*b +: 8] = {8{sizeStrb[b]}};
    end
  end

  assign misalignedAddr = |(laneOff & alignMask);
  assign reqLegal       = legalOp & ~misalignedAddr;
  assign laneWdata      = (req_data & dataMask) << {laneOff, 3'b000};
  assign laneWstrb      = sizeStrb << laneOff;

  assign req_ready = (occupancy != CNT_W'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign push      = accept & reqLegal & ~flush;
  assign pop       = mem_valid & mem_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      occupancy <= '0;
      misalignQ <= 1'b0;
    end else begin
      // A rejected request still pulses misalign even when a flush lands in the same cycle.
      misalignQ <= accept & ~reqLegal;
      if (flush) begin
        headPtr   <= '0;
        tailPtr   <= '0;
        occupancy <= '0;
      end else begin
        if (push) tailPtr <= tailPtr + 1'b1;
        if (pop)  headPtr <= headPtr + 1'b1;
        case ({push, pop})
          2'b10:   occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  // Entry storage carries no reset; only slots inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entAddr[tailPtr] <= wordAddr;
      entData[tailPtr] <= laneWdata;
      entStrb[tailPtr] <= laneWstrb;
    end
  end

  assign count     = occupancy;
  assign empty     = (occupancy == '0);
  assign mem_valid = ~empty;
  assign misalign  = misalignQ;
  assign mem_addr  = entAddr[headPtr];
  assign mem_wdata = entData[headPtr];
  assign mem_wstrb = entStrb[headPtr];

`ifdef STORE_BUF_FWD_EN
  logic [XLEN-1:0]   fwdDataC;
  logic [STRB_W-1:0] fwdStrbC;
  logic [PTR_W-1:0]  probeIdx;
  logic              unusedFwdLow;

  // Walk oldest to youngest so a younger matching byte overwrites an older one.
  always_comb begin
    fwdDataC = '0;
    fwdStrbC = '0;
    probeIdx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      probeIdx = headPtr + PTR_W'(k);
      if ((CNT_W'(k) < occupancy) &&
          (entAddr[probeIdx][ADDR_W-1:LANE_W] == fwd_addr[ADDR_W-1:LANE_W])) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (entStrb[probeIdx][b]) begin
            fwdDataC[8*b +: 8] = entData[probeIdx][8*b +: 8];
            fwdStrbC[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_data     = fwdDataC;
  assign fwd_strb     = fwdStrbC;
  assign fwd_hit      = |fwdStrbC;
  assign unusedFwdLow = ^fwd_addr[LANE_W-1:0];
`else
  logic unusedFwd;

  assign fwd_data  = '0;
  assign fwd_strb  = '0;
  assign fwd_hit   = 1'b0;
  assign unusedFwd = ^fwd_addr;
`endif

endmodule
